store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Memory-stage store executor, directly downstream of decode_store.
- Consumes the decoded store_kind_t together with the rs1 base, the S-type immediate and the rs2 data.
- Computes the effective address and checks alignment.
- Issues a single byte-strobed, word-aligned write on the data-memory bus with a valid/ready handshake, then reports completion or fault to the pipeline control.

Parameters:
XLEN, 32, data and address width (only 32 supported)
IMM_WIDTH, 12, width of the signed store immediate

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request
kind  input  store_kind_t  sk_sb / sk_sh / sk_sw / sk_invalid, from decode_store
base  input  XLEN  rs1 value
offset  input  IMM_WIDTH  signed immediate
wdata  input  XLEN  rs2 value
mem_valid  output  1  write request to memory
mem_ready  input  1  memory accepts write
mem_addr  output  XLEN  word-aligned write address
mem_wdata  output  XLEN  lane-replicated write data
mem_strb  output  4  byte enables
done_valid  output  1  one-cycle completion pulse
done_cause  output  2  00 ok, 01 misaligned, 10 invalid kind

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states IDLE, BUS, RESP. Reset forces IDLE.
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_strb=0, done_valid=0, done_cause=00.
- req_ready: req_ready=1 exactly when state==IDLE and rst==0. It is 0 during any cycle with rst high.
- Accept: a request is accepted when req_valid && req_ready in IDLE. kind, base, offset and wdata are registered in that cycle.
- Effective address: ea = base + sign_extend(offset), modulo 2^32; wrap-around is silent.
- Fault check, priority order:
  - kind==sk_invalid -> cause 10.
  - sk_sh with ea[0]!=0, or sk_sw with ea[1:0]!=0 -> cause 01.
  - sk_sb is never misaligned.
- Fault path: IDLE -> RESP directly. mem_valid is never asserted and no memory side effect occurs.
- Normal path: IDLE -> BUS.
  - In BUS: mem_valid=1, mem_addr={ea[31:2],2'b00}.
  - mem_strb: sb = 4'b0001<<ea[1:0]; sh = 4'b0011<<ea[1:0]; sw = 4'b1111.
  - mem_wdata: sb = byte wdata[7:0] replicated 4x; sh = wdata[15:0] replicated 2x; sw = wdata.
- Bus handshake: mem_addr, mem_wdata and mem_strb stay stable while mem_valid=1 && mem_ready=0. On mem_valid && mem_ready: BUS -> RESP, and mem_valid deasserts in the next cycle.
- Outputs outside BUS: mem_valid=0, mem_strb=0.
- RESP: done_valid=1 and done_cause valid for exactly one cycle, then -> IDLE. req_ready is 0 in RESP, so there are no back-to-back accepts.
- Latency:
  - Accept at edge N -> mem_valid high in cycle N+1.
  - If mem_ready=1 in N+1 -> done_valid in N+2, req_ready=1 in N+3.
  - Fault: done_valid in N+1.
  - Each cycle of memory backpressure adds one cycle.
- Reset mid-operation: rst high in BUS or RESP returns to IDLE on that edge. mem_valid and done_valid are 0 from the next cycle; the pending store is dropped with no done pulse.
- mem_ready while not in BUS is ignored. req_valid outside IDLE is ignored; the producer holds its request until req_ready.

Test Plan:
- SB: base=0x1000, offset=3, wdata=0x11223344, mem_ready=1 -> mem_addr=0x1000, strb=1000, wdata=0x44444444; done_valid 2 cycles after accept with cause 00.
- SH misaligned: base=0x2001, offset=0 -> no mem_valid; done_valid next cycle with cause 01. SH at ea=0x2002 -> strb=1100, wdata={h,h}.
- SW with backpressure: ea=0x3000, mem_ready low 3 cycles -> mem_valid held 4 cycles with addr/data/strb stable, wdata=rs2, strb=1111; single done pulse with cause 00.
- Invalid kind -> done_cause=10, no bus write. Negative offset: base=0x10, offset=-4 (0xFFC) SW -> mem_addr=0x0C.
- Wrap-around: base=0xFFFFFFFE, offset=2, SW -> mem_addr=0x00000000, cause 00.
- Reset mid-BUS: assert rst while mem_valid=1 and mem_ready=0 -> next cycle mem_valid=0, no done_valid, req_ready=1 after rst falls; a new SB then completes normally.

Source files
------------

// File: rtl/store_unit.sv
// Memory-stage store executor: computes the effective address, checks
// alignment and issues one byte-strobed word write per store.
package store_pkg;
    typedef enum logic [1:0] {
        sk_sb      = 2'd0,
        sk_sh      = 2'd1,
        sk_sw      = 2'd2,
        sk_invalid = 2'd3
    } store_kind_t;
endpackage

module store_unit
    import store_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  store_kind_t          kind,
    input  logic [XLEN-1:0]      base,
    input  logic [IMM_WIDTH-1:0] offset,
    input  logic [XLEN-1:0]      wdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_strb,
    output logic                 done_valid,
    output logic [1:0]           done_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_strb;
    logic [1:0]        r_cause;

    logic              w_accept;
    logic              w_fault;
    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_imm;
    logic [1:0]        w_cause;
    logic [3:0]        w_strb;
    logic [XLEN-1:0]   w_wdata;

    // Address arithmetic wraps silently modulo 2^XLEN.
    assign w_imm = {{(XLEN-IMM_WIDTH){offset[IMM_WIDTH-1]}}, offset};
    assign w_ea  = base + w_imm;

    always_comb begin
        w_cause = 2'b00;
        unique case (1'b1)
            (kind == sk_invalid):              w_cause = 2'b10;
            (kind == sk_sh && w_ea[0]):        w_cause = 2'b01;
            (kind == sk_sw && |w_ea[1:0]):     w_cause = 2'b01;
            default:                           w_cause = 2'b00;
        endcase
    end

    assign w_fault = (w_cause != 2'b00);

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = wdata;
        unique case (kind)
            sk_sb: begin
                w_strb  = 4'b0001 << w_ea[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            sk_sh: begin
                w_strb  = 4'b0011 << w_ea[1:0];
                w_wdata = {2{wdata[15:0]}};
            end
            sk_sw: begin
                w_strb  = 4'b1111;
                w_wdata = wdata;
            end
            default: begin
                w_strb  = 4'b0000;
                w_wdata = wdata;
            end
        endcase
    end

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fault ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bus fields load only on a clean accept, so they stay frozen under
    // backpressure and a faulting store leaves the bus untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= 4'b0000;
            r_cause <= 2'b00;
        end else if (w_accept) begin
            r_cause <= w_cause;
            if (!w_fault) begin
                r_addr  <= {w_ea[XLEN-1:2], 2'b00};
                r_wdata <= w_wdata;
                r_strb  <= w_strb;
            end
        end
    end

    assign mem_valid  = (r_state == S_BUS);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_strb   = mem_valid ? r_strb : 4'b0000;
    assign done_valid = (r_state == S_RESP);
    assign done_cause = done_valid ? r_cause : 2'b00;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: transaction-level reference model, per-cycle
// compare, directed literal cases and randomized traffic.
module tb_store_unit;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    store_kind_t kind = sk_sb;
    logic [31:0] base = '0;
    logic [11:0] offset = '0;
    logic [31:0] wdata = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        done_valid;
    logic [1:0]  done_cause;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;
    bit mr_hold = 1;

    // model: what the unit is doing, in transaction terms
    bit          m_idle = 1;
    bit          m_bus = 0;
    bit          m_done = 0;
    logic [1:0]  m_cause = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_data = 0;
    logic [3:0]  m_strb = 0;

    store_unit #(.XLEN(32), .IMM_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .kind(kind), .base(base), .offset(offset), .wdata(wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
        .done_valid(done_valid), .done_cause(done_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int sz;
        logic signed [31:0] so;
        logic [31:0] ea;
        if (rst) begin
            m_idle = 1; m_bus = 0; m_done = 0;
        end else if (m_idle) begin
            if (req_valid) begin
                so = 32'(signed'(offset));
                ea = base + so;
                sz = (kind == sk_sb) ? 1 : (kind == sk_sh) ? 2 : 4;
                m_idle = 0;
                if (kind == sk_invalid) m_cause = 2'b10;
                else if ((ea % sz) != 0) m_cause = 2'b01;
                else m_cause = 2'b00;
                if (m_cause != 0) begin
                    m_done = 1;
                end else begin
                    m_bus = 1;
                    m_addr = ea - (ea % 4);
                    m_strb = 4'(((1 << sz) - 1) << (ea % 4));
                    if (sz == 1) m_data = {24'h0, wdata[7:0]} * 32'h01010101;
                    else if (sz == 2) m_data = {16'h0, wdata[15:0]} * 32'h00010001;
                    else m_data = wdata;
                end
            end
        end else if (m_bus) begin
            if (mem_ready) begin
                m_bus = 0; m_done = 1; m_cause = 2'b00;
            end
        end else if (m_done) begin
            m_done = 0; m_idle = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", {31'h0, req_ready}, {31'h0, m_idle && !rst});
            chk("mem_valid", {31'h0, mem_valid}, {31'h0, m_bus});
            chk("done_valid", {31'h0, done_valid}, {31'h0, m_done});
            if (m_bus) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_data);
                chk("mem_strb", {28'h0, mem_strb}, {28'h0, m_strb});
            end else begin
                chk("strb_idle", {28'h0, mem_strb}, 32'h0);
            end
            if (m_done) chk("done_cause", {30'h0, done_cause}, {30'h0, m_cause});
        end
    end

    always @(posedge clk) begin
        #1;
        if (!mr_hold) mem_ready = ($urandom_range(0, 2) != 0);
    end

    // Presents a request and holds it until accepted; returns 1ns after
    // the accepting edge.
    task automatic issue(input store_kind_t k, input logic [31:0] b,
                         input logic [11:0] o, input logic [31:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        kind = k; base = b; offset = o; wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_strb", {28'h0, mem_strb}, 32'h0);
        chk("rst_done_valid", {31'h0, done_valid}, 32'h0);
        chk("rst_done_cause", {30'h0, done_cause}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        cmp_en = 1;
        @(posedge clk); #1 rst = 1'b0;

        mem_ready = 1'b1;
        issue(sk_sb, 32'h1000, 12'd3, 32'h11223344);
        @(negedge clk);
        chk("sb_valid", {31'h0, mem_valid}, 32'h1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_strb", {28'h0, mem_strb}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'h44444444);
        @(negedge clk);
        chk("sb_done", {31'h0, done_valid}, 32'h1);
        chk("sb_cause", {30'h0, done_cause}, 32'h0);
        @(negedge clk);
        chk("sb_ready_back", {31'h0, req_ready}, 32'h1);

        issue(sk_sh, 32'h2001, 12'd0, 32'h0000BEEF);
        @(negedge clk);
        chk("shm_no_bus", {31'h0, mem_valid}, 32'h0);
        chk("shm_done", {31'h0, done_valid}, 32'h1);
        chk("shm_cause", {30'h0, done_cause}, 32'h1);

        issue(sk_sh, 32'h2000, 12'd2, 32'hAABBCCDD);
        @(negedge clk);
        chk("sh_strb", {28'h0, mem_strb}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hCCDDCCDD);
        chk("sh_addr", mem_addr, 32'h2000);

        @(posedge clk); #1 mem_ready = 1'b0;
        issue(sk_sw, 32'h3000, 12'd0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_bp_valid", {31'h0, mem_valid}, 32'h1);
            chk("sw_bp_addr", mem_addr, 32'h3000);
            chk("sw_bp_wdata", mem_wdata, 32'hDEADBEEF);
            chk("sw_bp_strb", {28'h0, mem_strb}, 32'hF);
            chk("sw_bp_nodone", {31'h0, done_valid}, 32'h0);
            mem_ready = (i == 3);
        end
        @(negedge clk);
        chk("sw_done", {31'h0, done_valid}, 32'h1);
        chk("sw_cause", {30'h0, done_cause}, 32'h0);
        chk("sw_valid_off", {31'h0, mem_valid}, 32'h0);
        @(negedge clk);
        chk("sw_single_pulse", {31'h0, done_valid}, 32'h0);

        issue(sk_invalid, 32'h4000, 12'd0, 32'h1);
        @(negedge clk);
        chk("inv_no_bus", {31'h0, mem_valid}, 32'h0);
        chk("inv_cause", {30'h0, done_cause}, 32'h2);

        issue(sk_sw, 32'h10, 12'hFFC, 32'h12345678);
        @(negedge clk);
        chk("neg_addr", mem_addr, 32'h0000000C);

        issue(sk_sw, 32'hFFFFFFFE, 12'd2, 32'h87654321);
        @(negedge clk);
        chk("wrap_addr", mem_addr, 32'h00000000);
        @(negedge clk);
        chk("wrap_cause", {30'h0, done_cause}, 32'h0);

        @(posedge clk); #1 mem_ready = 1'b0;
        issue(sk_sw, 32'h5000, 12'd4, 32'hCAFEF00D);
        @(negedge clk);
        chk("rb_valid", {31'h0, mem_valid}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rb_ready_in_rst", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rb_valid_off", {31'h0, mem_valid}, 32'h0);
        chk("rb_no_done", {31'h0, done_valid}, 32'h0);
        chk("rb_ready", {31'h0, req_ready}, 32'h1);
        mem_ready = 1'b1;
        issue(sk_sb, 32'h40, 12'd1, 32'h0000005A);
        @(negedge clk);
        chk("rb_sb_strb", {28'h0, mem_strb}, 32'h2);
        chk("rb_sb_wdata", mem_wdata, 32'h5A5A5A5A);
        @(negedge clk);
        chk("rb_sb_done", {31'h0, done_valid}, 32'h1);

        mr_hold = 0;
        for (int t = 0; t < 300; t++) begin
            store_kind_t k;
            logic [31:0] b;
            k = store_kind_t'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            b = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            issue(k, b, 12'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
